ecg_mavg_notch: RTL

//  Downstream of the MCP3202 SPI sampler: takes each 12-bit sample (data/dv, 500 sps) and

---
 rtl/ecg_pkg.sv | 14 +
 rtl/ecg_mavg_ring.sv | 31 +++
 rtl/ecg_mavg_notch.sv | 96 +++++++++
 3 files changed

// File: rtl/ecg_pkg.sv
// Shared constants for the ECG front end: ADC format, sample rate and the
// window length that nulls 50 Hz mains at that rate.
package ecg_pkg;
    localparam int ADC_DW      = 12;
    localparam int FS_HZ       = 500;
    localparam int N_TAPS_50HZ = FS_HZ / 50;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ecg_mavg_ring.sv
// N_TAPS-deep sample ring. The entry under the write pointer is the oldest one,
// so it is presented combinationally in the same cycle it gets overwritten.
module ecg_mavg_ring
    import ecg_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_50HZ,
    parameter int DW     = ADC_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] old
);
    localparam int PW = clog2(N_TAPS);

    logic [N_TAPS-1:0][DW-1:0] ring;
    logic [PW-1:0]             wptr;

    assign old = ring[wptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring <= '0;
            wptr <= '0;
        end else if (we) begin
            ring[wptr] <= wdata;
            wptr       <= (wptr == PW'(N_TAPS - 1)) ? '0 : wptr + PW'(1);
        end
    end
endmodule

// File: rtl/ecg_mavg_notch.sv
// N-sample moving average (comb notch at fs/N and harmonics) with a
// reciprocal-multiply divide and a single-entry valid/ready output register.
module ecg_mavg_notch
    import ecg_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_50HZ,
    parameter int DW     = ADC_DW,
    parameter int SHIFT  = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] i_data,
    input  logic          i_dv,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_primed,
    output logic          o_ovf
);
    localparam int SW = DW + clog2(N_TAPS);
    localparam int PW = SW + SHIFT + 1;
    localparam int CW = clog2(N_TAPS);
    localparam longint unsigned RECIP_L = ((64'd1 << SHIFT) + longint'(N_TAPS) - 1) / longint'(N_TAPS);
    localparam logic [SHIFT:0]  RECIP   = RECIP_L[SHIFT:0];
    localparam longint unsigned SUM_MAX = longint'(N_TAPS) * ((64'd1 << DW) - 1);

    // Rounding-up error of RECIP must stay below one LSB of the quotient over the full sum range.
    if (SUM_MAX * (RECIP_L * longint'(N_TAPS) - (64'd1 << SHIFT)) >= (64'd1 << SHIFT)) begin : g_bad_shift
        $error("ecg_mavg_notch: SHIFT too small for exact division by N_TAPS");
    end
    if (N_TAPS < 2 || N_TAPS > 64) begin : g_bad_taps
        $error("ecg_mavg_notch: N_TAPS out of range 2..64");
    end

    logic          dv_q;
    logic          smp;
    logic [DW-1:0] old;
    logic [SW-1:0] sum;
    logic [PW-1:0] prod;
    logic [1:0]    vld_pipe;
    logic [CW-1:0] prime_cnt;

    assign smp = i_dv & ~dv_q;

    ecg_mavg_ring #(.N_TAPS(N_TAPS), .DW(DW)) u_ring (
        .clk   (clk),
        .rst   (rst),
        .we    (smp),
        .wdata (i_data),
        .old   (old)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q     <= 1'b0;
            sum      <= '0;
            prod     <= '0;
            vld_pipe <= '0;
        end else begin
            dv_q     <= i_dv;
            vld_pipe <= {vld_pipe[0], smp};
            // Never underflows: old was added into sum when it was written.
            if (smp)
                sum <= sum + SW'(i_data) - SW'(old);
            if (vld_pipe[0])
                prod <= PW'(sum) * PW'(RECIP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (vld_pipe[1]) begin
            o_data  <= DW'(prod >> SHIFT);
            o_valid <= 1'b1;
            if (o_valid && !i_ready)
                o_ovf <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_cnt <= '0;
            o_primed  <= 1'b0;
        end else if (smp && !o_primed) begin
            if (prime_cnt == CW'(N_TAPS - 1))
                o_primed <= 1'b1;
            else
                prime_cnt <= prime_cnt + CW'(1);
        end
    end
endmodule
